// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and the
// helper that maps log-levels onto pipeline stages.
package shifter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // First log-level owned by stage s: ceil(shw*s/stages).
  function automatic int unsigned lvl_lo(input int unsigned shw,
                                         input int unsigned stages,
                                         input int unsigned s);
    return (shw * s + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shifter_level.sv
// One log-level of the barrel shifter: conditional shift by 2^K in any of the
// four modes, updating the carry with the last bit shifted out.
module shifter_level
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned K     = 0
) (
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_carry,
  input  logic             en,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] dst_data,
  output logic             dst_carry
);

  localparam int unsigned SH     = 1 << K;
  localparam int unsigned HI_OUT = WIDTH - SH;
  localparam int unsigned LO_OUT = SH - 1;

  always_comb begin
    dst_data  = src_data;
    dst_carry = src_carry;
    if (en) begin
      case (op)
        OP_SLL: begin
          dst_data  = src_data << SH;
          dst_carry = src_data[HI_OUT];
        end
        OP_SRL: begin
          dst_data  = src_data >> SH;
          dst_carry = src_data[LO_OUT];
        end
        OP_SRA: begin
          // MSB stays the original sign across levels, so it is a valid fill source here
          dst_data  = WIDTH'($signed(src_data) >>> SH);
          dst_carry = src_data[LO_OUT];
        end
        default: begin
          dst_data  = (src_data << SH) | (src_data >> HI_OUT);
          dst_carry = src_data[HI_OUT];
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined, parametrised barrel shifter (SLL/SRL/SRA/ROL) with carry and zero
// flags and a valid/ready handshake with full backpressure on both sides.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned STAGES = 2,
  localparam int unsigned SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] load;

  logic [WIDTH-1:0] stg_d   [STAGES];
  logic             stg_c   [STAGES];
  logic [1:0]       stg_op  [STAGES];
  logic [SHW-1:0]   stg_amt [STAGES];
  logic [WIDTH-1:0] sout_d  [STAGES];
  logic             sout_c  [STAGES];
  logic [WIDTH-1:0] lvl_d   [SHW];
  logic             lvl_c   [SHW];

  // Stage s advances unless it and every stage after it are full while the sink stalls.
  always_comb begin : handshake
    logic full;
    full = 1'b1;
    adv  = '0;
    vin  = '0;
    for (int s = int'(LAST); s >= 0; s--) begin
      full   = full & vld_q[s];
      adv[s] = out_ready | ~full;
    end
    vin[0] = in_valid;
    for (int s = 1; s < int'(STAGES); s++) begin
      vin[s] = vld_q[s-1];
    end
    load = adv & vin;
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= (vld_q & ~adv) | (vin & adv);
    end
  end

  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
    localparam int unsigned LO = lvl_lo(SHW, STAGES, s);
    localparam int unsigned HI = lvl_lo(SHW, STAGES, s + 1);

    if (s == 0) begin : g_src
      assign stg_d[0]   = in_data;
      assign stg_c[0]   = 1'b0;
      assign stg_op[0]  = in_op;
      assign stg_amt[0] = in_amt;
    end else begin : g_reg
      logic [WIDTH-1:0] d_q;
      logic             c_q;
      logic [1:0]       op_q;
      logic [SHW-1:0]   amt_q;

      // Register at the end of stage s-1; only captures real beats.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q   <= '0;
          c_q   <= 1'b0;
          op_q  <= '0;
          amt_q <= '0;
        end else if (load[s-1]) begin
          d_q   <= sout_d[s-1];
          c_q   <= sout_c[s-1];
          op_q  <= stg_op[s-1];
          amt_q <= stg_amt[s-1];
        end
      end

      assign stg_d[s]   = d_q;
      assign stg_c[s]   = c_q;
      assign stg_op[s]  = op_q;
      assign stg_amt[s] = amt_q;
    end

    for (genvar k = int'(LO); k < int'(HI); k++) begin : g_lvl
      logic [WIDTH-1:0] src_d;
      logic             src_c;

      if (k == int'(LO)) begin : g_first
        assign src_d = stg_d[s];
        assign src_c = stg_c[s];
      end else begin : g_chain
        assign src_d = lvl_d[k-1];
        assign src_c = lvl_c[k-1];
      end

      shifter_level #(
        .WIDTH (WIDTH),
        .K     (k)
      ) u_level (
        .src_data  (src_d),
        .src_carry (src_c),
        .en        (stg_amt[s][k]),
        .op        (stg_op[s]),
        .dst_data  (lvl_d[k]),
        .dst_carry (lvl_c[k])
      );
    end

    assign sout_d[s] = lvl_d[HI-1];
    assign sout_c[s] = lvl_c[HI-1];
  end

  // Output register is the final stage; zero flag is taken before it so it aligns with data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (load[LAST]) begin
      out_data  <= sout_d[LAST];
      out_carry <= sout_c[LAST];
      out_zero  <= (sout_d[LAST] == '0);
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed and randomised checks for shifter_pipe: a 32-bit/2-stage instance
// driven with hand-computed vectors, plus a 16-bit/3-stage instance against a model.
module tb_shifter_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 2;
  localparam int unsigned SW = 16;
  localparam int unsigned SS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_carry, out_zero;
  logic [W-1:0]  in_data, out_data;
  logic [4:0]    in_amt;
  logic [1:0]    in_op;

  logic          s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_carry, s_out_zero;
  logic [SW-1:0] s_in_data, s_out_data;
  logic [3:0]    s_in_amt;
  logic [1:0]    s_in_op;

  int n_tests = 0;
  int n_fail  = 0;

  shifter_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_zero(out_zero)
  );

  shifter_pipe #(.WIDTH(SW), .STAGES(SS)) u_sweep (
    .clk(clk), .rst_n(s_rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_amt(s_in_amt), .in_op(s_in_op),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_carry(s_out_carry), .out_zero(s_out_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-level reference: each result bit picked directly from its source position.
  function automatic void ref_shift(input logic [63:0] d, input int w, input int n,
                                    input logic [1:0] op, output logic [63:0] r, output logic c);
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        2'b00:   r[i] = (i >= n) ? d[i-n] : 1'b0;
        2'b01:   r[i] = (i + n < w) ? d[i+n] : 1'b0;
        2'b10:   r[i] = (i + n < w) ? d[i+n] : d[w-1];
        default: r[i] = d[(i - n + w) % w];
      endcase
    end
    if (n == 0)                          c = 1'b0;
    else if (op == 2'b00 || op == 2'b11) c = d[w-n];
    else                                 c = d[n-1];
  endfunction

  task automatic send_one(input string tag, input logic [1:0] op, input logic [4:0] amt,
                          input logic [31:0] d, input logic [31:0] exp_d,
                          input logic exp_c, input logic exp_z);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_amt = amt; in_data = d; out_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},   64'(lat), 64'(S));
    check({tag, "_data"},  64'(out_data), 64'(exp_d));
    check({tag, "_carry"}, 64'(out_carry), 64'(exp_c));
    check({tag, "_zero"},  64'(out_zero), 64'(exp_z));
    @(posedge clk); #1;
    check({tag, "_alone"}, 64'(out_valid), 64'd0);
  endtask

  task automatic main_seq();
    int acc;
    logic [31:0] one;
    one = 32'd1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_amt = '0; in_op = '0;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_carry", 64'(out_carry), 64'd0);
    check("rst_zero",  64'(out_zero),  64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_ready", 64'(in_ready), 64'd1);

    send_one("sll4",    2'b00, 5'd4,  32'h0000_00F1, 32'h0000_0F10, 1'b0, 1'b0);
    send_one("sra31",   2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send_one("srl31",   2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    send_one("srl1",    2'b01, 5'd1,  32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0);
    send_one("rol1",    2'b11, 5'd1,  32'h8000_0001, 32'h0000_0003, 1'b1, 1'b0);
    send_one("sll_z",   2'b00, 5'd1,  32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
    send_one("rol0",    2'b11, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    send_one("sra_pos", 2'b10, 5'd31, 32'h4000_0000, 32'h0000_0000, 1'b1, 1'b1);
    send_one("rol31",   2'b11, 5'd31, 32'h8000_0002, 32'h4000_0001, 1'b1, 1'b0);

    // Back-to-back stream: 1 << c, one result per cycle after the pipeline fills.
    for (int c = 0; c < 8 + int'(S) + 1; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (c < 8);
      in_op = 2'b00; in_data = 32'h1; in_amt = 5'(c);
      #1;
      check("stream_rdy", 64'(in_ready), 64'd1);
      check("stream_vld", 64'(out_valid), 64'((c >= int'(S)) && (c < 8 + int'(S))));
      if (out_valid) check("stream_data", 64'(out_data), 64'(one << (c - int'(S))));
    end

    // Backpressure: two beats fill the pipe, then in_ready drops and output holds.
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b01; in_data = 32'hF000_0000;
      in_amt = (acc == 0) ? 5'd4 : (acc == 1) ? 5'd8 : 5'd12;
      #1;
      check("bp_rdy", 64'(in_ready), 64'(c < 2));
      check("bp_vld", 64'(out_valid), 64'(c >= 2));
      if (c >= 2) check("bp_hold", 64'(out_data), 64'h0F00_0000);
      if (in_ready) acc++;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
    check("drain0_vld",  64'(out_valid), 64'd1);
    check("drain0_data", 64'(out_data), 64'h0F00_0000);
    @(negedge clk); #1;
    check("drain1_vld",  64'(out_valid), 64'd1);
    check("drain1_data", 64'(out_data), 64'h00F0_0000);
    @(negedge clk); #1;
    check("drain2_vld",  64'(out_valid), 64'd0);

    // Reset with two beats in flight.
    @(negedge clk); in_valid = 1'b1; in_op = 2'b11; in_amt = 5'd1; in_data = 32'h1; out_ready = 1'b1;
    @(negedge clk); in_data = 32'h2;
    @(negedge clk); in_valid = 1'b0; #1;
    check("pre_rst_vld", 64'(out_valid), 64'd1);
    rst_n = 1'b0; #1;
    check("mid_rst_vld",  64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    send_one("post_rst", 2'b11, 5'd5, 32'h0000_0001, 32'h0000_0020, 1'b0, 1'b0);
  endtask

  task automatic sweep_seq();
    logic [63:0] q_d[$];
    logic        q_c[$];
    int          q_t[$];
    logic [63:0] rd, ed;
    logic        rc, ec;
    int          t;
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_in_data = '0; s_in_amt = '0; s_in_op = '0;
    repeat (2) @(negedge clk);
    s_rst_n = 1'b1;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      s_in_valid  = (c < 110) && ($urandom_range(0, 3) != 0);
      s_in_data   = 16'($urandom);
      s_in_amt    = 4'($urandom);
      s_in_op     = 2'($urandom);
      s_out_ready = (c < 50 || c >= 110) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #4;
      if (s_out_valid && s_out_ready) begin
        if (q_d.size() == 0) begin
          check("sw_spurious", 64'd1, 64'd0);
        end else begin
          ed = q_d.pop_front(); ec = q_c.pop_front(); t = q_t.pop_front();
          check("sw_data",  64'(s_out_data), ed);
          check("sw_carry", 64'(s_out_carry), 64'(ec));
          check("sw_zero",  64'(s_out_zero), 64'(ed == 64'd0));
          if (c < 50) check("sw_lat", 64'(c - t), 64'(SS));
        end
      end
      if (s_in_valid && s_in_ready) begin
        ref_shift(64'(s_in_data), int'(SW), int'(s_in_amt), s_in_op, rd, rc);
        q_d.push_back(rd); q_c.push_back(rc); q_t.push_back(c);
      end
    end
    check("sw_drain", 64'(q_d.size()), 64'd0);
  endtask

  initial begin
    fork
      main_seq();
      sweep_seq();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
